// File: rtl/cnt_stream_chk.sv
// rtl/cnt_stream_chk.sv - step/lock checker for an 8-bit counter stream (optional error counter: CNT_STREAM_CHK_ERR_CNT_EN)
module cnt_stream_chk #(
    parameter int unsigned STEP   = 2,
    parameter int unsigned LOCK_N = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] cnt_i,
    input  logic       en_i,
    output logic       locked_o,
    output logic       err_o,
    output logic       wrap_o,
    output logic [7:0] err_cnt_o,
    output logic [7:0] wrap_cnt_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOCK  = 2'd1,
        TRACK = 2'd2
    } state_t;

    localparam logic [7:0] STEP_B   = 8'(STEP);
    localparam logic [3:0] LOCK_N_B = 4'(LOCK_N);

    state_t     state_q, state_d;
    logic [7:0] prev_q, prev_d;
    logic [3:0] match_q, match_d;
    logic       locked_q, locked_d;
    logic       err_q, err_d;
    logic       wrap_q, wrap_d;
    logic [7:0] wrap_cnt_q, wrap_cnt_d;

    logic [7:0] exp_val;
    logic       step_ok;

    // The expected value wraps naturally through 8-bit truncation.
    assign exp_val = prev_q + STEP_B;
    assign step_ok = (cnt_i == exp_val);

    // Next-state and pulse decode; nothing moves while en_i is low.
    always_comb begin
        state_d    = state_q;
        prev_d     = prev_q;
        match_d    = match_q;
        err_d      = 1'b0;
        wrap_d     = 1'b0;
        wrap_cnt_d = wrap_cnt_q;
        if (en_i) begin
            prev_d = cnt_i;
            case (state_q)
                IDLE: begin
                    match_d = 4'd0;
                    state_d = LOCK;
                end
                LOCK: begin
                    if (step_ok) begin
                        match_d = match_q + 4'd1;
                        if (match_d == LOCK_N_B) begin
                            state_d = TRACK;
                        end
                    end else begin
                        match_d = 4'd0;
                    end
                end
                TRACK: begin
                    if (step_ok) begin
                        // A correct step that lands below the previous value crossed 255.
                        if (cnt_i < prev_q) begin
                            wrap_d     = 1'b1;
                            wrap_cnt_d = wrap_cnt_q + 8'd1;
                        end
                    end else begin
                        err_d   = 1'b1;
                        match_d = 4'd0;
                        state_d = LOCK;
                    end
                end
                default: begin
                    match_d = 4'd0;
                    state_d = IDLE;
                end
            endcase
        end
    end

    // locked_o follows the next state so it rises with the final lock match.
    assign locked_d = (state_d == TRACK);

    // State and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            prev_q     <= 8'd0;
            match_q    <= 4'd0;
            locked_q   <= 1'b0;
            err_q      <= 1'b0;
            wrap_q     <= 1'b0;
            wrap_cnt_q <= 8'd0;
        end else begin
            state_q    <= state_d;
            prev_q     <= prev_d;
            match_q    <= match_d;
            locked_q   <= locked_d;
            err_q      <= err_d;
            wrap_q     <= wrap_d;
            wrap_cnt_q <= wrap_cnt_d;
        end
    end

`ifdef CNT_STREAM_CHK_ERR_CNT_EN
    logic [7:0] err_cnt_q;

    // Error tally saturates at 255 so a long fault burst stays visible.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_cnt_q <= 8'd0;
        end else if (err_d && (err_cnt_q != 8'hFF)) begin
            err_cnt_q <= err_cnt_q + 8'd1;
        end
    end

    assign err_cnt_o = err_cnt_q;
`else
    assign err_cnt_o = 8'd0;
`endif

    assign locked_o   = locked_q;
    assign err_o      = err_q;
    assign wrap_o     = wrap_q;
    assign wrap_cnt_o = wrap_cnt_q;

endmodule

// File: tb/tb_cnt_stream_chk.sv
// tb/tb_cnt_stream_chk.sv - self-checking bench for cnt_stream_chk
module tb_cnt_stream_chk;

    localparam int STEP   = 2;
    localparam int LOCK_N = 4;
`ifdef CNT_STREAM_CHK_ERR_CNT_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic       clk;
    logic       reset;
    logic [7:0] cnt_i;
    logic       en_i;
    logic       locked_o;
    logic       err_o;
    logic       wrap_o;
    logic [7:0] err_cnt_o;
    logic [7:0] wrap_cnt_o;

    cnt_stream_chk #(.STEP(STEP), .LOCK_N(LOCK_N)) dut (
        .clk        (clk),
        .reset      (reset),
        .cnt_i      (cnt_i),
        .en_i       (en_i),
        .locked_o   (locked_o),
        .err_o      (err_o),
        .wrap_o     (wrap_o),
        .err_cnt_o  (err_cnt_o),
        .wrap_cnt_o (wrap_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: remembers the last sample and counts a run of good steps.
    bit   m_started;
    int   m_prev;
    int   m_run;
    bit   m_locked;
    int   m_errs;
    int   m_wraps;
    bit   m_err;
    bit   m_wrap;

    typedef struct {
        bit rst;
        bit en;
        int cnt;
        bit locked;
        bit err;
        bit wrap;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_started = 0;
        m_prev    = 0;
        m_run     = 0;
        m_locked  = 0;
        m_errs    = 0;
        m_wraps   = 0;
        m_err     = 0;
        m_wrap    = 0;
    endtask

    task automatic model_step(input bit en, input int cnt);
        bit ok;
        m_err  = 0;
        m_wrap = 0;
        if (!en) return;
        if (!m_started) begin
            m_started = 1;
            m_run     = 0;
        end else begin
            ok = (cnt == ((m_prev + STEP) % 256));
            if (m_locked) begin
                if (ok) begin
                    if (cnt < m_prev) begin
                        m_wrap  = 1;
                        m_wraps = (m_wraps + 1) % 256;
                    end
                end else begin
                    m_err    = 1;
                    m_errs   = (m_errs < 255) ? m_errs + 1 : 255;
                    m_locked = 0;
                    m_run    = 0;
                end
            end else if (ok) begin
                m_run++;
                if (m_run >= LOCK_N) m_locked = 1;
            end else begin
                m_run = 0;
            end
        end
        m_prev = cnt;
    endtask

    task automatic chk_model();
        chk("locked", int'(locked_o), int'(m_locked));
        chk("err", int'(err_o), int'(m_err));
        chk("wrap", int'(wrap_o), int'(m_wrap));
        chk("err_cnt", int'(err_cnt_o), ERR_EN ? m_errs : 0);
        chk("wrap_cnt", int'(wrap_cnt_o), m_wraps);
    endtask

    task automatic apply(input bit en, input int cnt);
        en_i  = en;
        cnt_i = 8'(cnt);
        model_step(en, cnt);
        @(posedge clk);
        #1;
        chk_model();
    endtask

    task automatic do_reset();
        en_i  = 1'b0;
        reset = 1'b0;
        model_reset();
        #2;
        chk("rst_locked", int'(locked_o), 0);
        chk("rst_err", int'(err_o), 0);
        chk("rst_wrap", int'(wrap_o), 0);
        chk("rst_err_cnt", int'(err_cnt_o), 0);
        chk("rst_wrap_cnt", int'(wrap_cnt_o), 0);
        #1;
        reset = 1'b1;
    endtask

    function automatic void add(input bit rst, input bit en, input int cnt,
                                input bit l, input bit e, input bit w);
        vec_t v;
        v.rst = rst; v.en = en; v.cnt = cnt; v.locked = l; v.err = e; v.wrap = w;
        vecs.push_back(v);
    endfunction

    initial begin
        int d_prev;
        int c;
        reset = 1'b1;
        en_i  = 1'b0;
        cnt_i = 8'd0;
        model_reset();
        @(posedge clk);
        #1;

        // Lock acquisition
        add(1, 1, 1, 0, 0, 0); add(0, 1, 3, 0, 0, 0); add(0, 1, 5, 0, 0, 0);
        add(0, 1, 7, 0, 0, 0); add(0, 1, 9, 1, 0, 0);
        // Wrap
        add(1, 1, 241, 0, 0, 0); add(0, 1, 243, 0, 0, 0); add(0, 1, 245, 0, 0, 0);
        add(0, 1, 247, 0, 0, 0); add(0, 1, 249, 1, 0, 0); add(0, 1, 251, 1, 0, 0);
        add(0, 1, 253, 1, 0, 0); add(0, 1, 255, 1, 0, 0); add(0, 1, 1, 1, 0, 1);
        add(0, 1, 3, 1, 0, 0);
        // Error and relock
        add(1, 1, 3, 0, 0, 0); add(0, 1, 5, 0, 0, 0); add(0, 1, 7, 0, 0, 0);
        add(0, 1, 9, 0, 0, 0); add(0, 1, 11, 1, 0, 0); add(0, 1, 15, 0, 1, 0);
        add(0, 1, 17, 0, 0, 0); add(0, 1, 19, 0, 0, 0); add(0, 1, 21, 0, 0, 0);
        add(0, 1, 23, 1, 0, 0);
        // Enable hold
        add(1, 1, 33, 0, 0, 0); add(0, 1, 35, 0, 0, 0); add(0, 1, 37, 0, 0, 0);
        add(0, 1, 39, 0, 0, 0); add(0, 1, 41, 1, 0, 0); add(0, 0, 99, 1, 0, 0);
        add(0, 0, 99, 1, 0, 0); add(0, 0, 99, 1, 0, 0); add(0, 1, 43, 1, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].rst) do_reset();
            apply(vecs[i].en, vecs[i].cnt);
            chk($sformatf("vec%0d_locked", i), int'(locked_o), int'(vecs[i].locked));
            chk($sformatf("vec%0d_err", i), int'(err_o), int'(vecs[i].err));
            chk($sformatf("vec%0d_wrap", i), int'(wrap_o), int'(vecs[i].wrap));
            if (i == 14) chk("wrap_cnt_after_wrap", int'(wrap_cnt_o), 1);
            if (i == 20) chk("err_cnt_after_err", int'(err_cnt_o), ERR_EN ? 1 : 0);
        end

        // Randomized stream: mostly good steps, some glitches and idle cycles
        do_reset();
        d_prev = $urandom_range(0, 255);
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                apply(0, $urandom_range(0, 255));
            end else begin
                if ($urandom_range(0, 15) == 0) c = $urandom_range(0, 255);
                else c = (d_prev + STEP) % 256;
                d_prev = c;
                apply(1, c);
            end
        end

        // Saturation: repeated mismatch then relock
        do_reset();
        d_prev = 0;
        apply(1, d_prev);
        for (int k = 0; k < LOCK_N; k++) begin
            d_prev = (d_prev + STEP) % 256;
            apply(1, d_prev);
        end
        for (int i = 0; i < 300; i++) begin
            d_prev = (d_prev + STEP + 1) % 256;
            apply(1, d_prev);
            for (int k = 0; k < LOCK_N; k++) begin
                d_prev = (d_prev + STEP) % 256;
                apply(1, d_prev);
            end
        end
        chk("err_cnt_saturated", int'(err_cnt_o), ERR_EN ? 255 : 0);
        chk("locked_before_async_rst", int'(locked_o), 1);

        // Asynchronous reset between edges
        #2;
        reset = 1'b0;
        #1;
        chk("async_locked", int'(locked_o), 0);
        chk("async_err", int'(err_o), 0);
        chk("async_wrap", int'(wrap_o), 0);
        chk("async_err_cnt", int'(err_cnt_o), 0);
        chk("async_wrap_cnt", int'(wrap_cnt_o), 0);
        #1;
        reset = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        // First sample after release is a capture, not a compare
        apply(1, 200);
        apply(1, 202);
        apply(1, 7);
        chk("post_rst_err", int'(err_o), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
